// File: rtl/spdif_frame_sequencer_if.sv
// Sample-input and subframe-output bundle between the I2S side, the frame sequencer
// and the biphase serializer.
interface spdif_frame_sequencer_if;
    logic        in_valid;
    logic        in_chan;
    logic [23:0] in_data;
    logic [31:0] cs_bits;
    logic        sf_ready;
    logic        sf_valid;
    logic [1:0]  sf_preamble;
    logic [27:0] sf_payload;
    logic [7:0]  frame_idx;
    logic        locked;
    logic [15:0] underrun_cnt;

    modport master (
        output in_valid, in_chan, in_data, cs_bits, sf_ready,
        input  sf_valid, sf_preamble, sf_payload, frame_idx, locked, underrun_cnt
    );

    modport slave (
        input  in_valid, in_chan, in_data, cs_bits, sf_ready,
        output sf_valid, sf_preamble, sf_payload, frame_idx, locked, underrun_cnt
    );
endinterface

// File: rtl/spdif_frame_sequencer.sv
// Pairs I2S L/R strobes into stereo frames and emits one S/PDIF subframe at a time,
// sequencing the 192-frame block and muting when unlocked or starved.
module spdif_frame_sequencer #(
    parameter int unsigned LOCK_PAIRS  = 4,
    parameter int unsigned TIMEOUT_CYC = 2048,
    parameter logic [31:0] CS_DEFAULT  = 32'h0
) (
    input  logic clk,
    input  logic rst,
    spdif_frame_sequencer_if.slave bus
);
    localparam int unsigned AW   = 24;
    localparam int unsigned FW   = 8;
    localparam int unsigned UW   = 16;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PC_W = $clog2(LOCK_PAIRS + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(191);
    localparam logic [1:0] PRE_B = 2'd0;
    localparam logic [1:0] PRE_M = 2'd1;
    localparam logic [1:0] PRE_W = 2'd2;

    typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} lock_state_t;

    lock_state_t     state, state_next;
    logic [PC_W-1:0] pair_cnt, pair_cnt_next;
    logic            locked_q, locked_next;
    logic [WD_W-1:0] wd;

    logic            half, full;
    logic [AW-1:0]   pend_l, pair_l, pair_r;

    logic            sf_valid_q, is_right, v_hold;
    logic [1:0]      preamble_q;
    logic [27:0]     payload_q;
    logic [FW-1:0]   frame_q;
    logic [AW-1:0]   aud_r;
    logic [UW-1:0]   underrun_q;
    logic [31:0]     cs_latch;

    logic            strobe_l_c, strobe_r_c, pair_done_c, timeout_c;
    logic            present_c, next_right_c, fetch_c, take_c, wrap_c, c_bit_c, v_c;
    logic [FW-1:0]   frame_next_c;
    logic [31:0]     cs_eff_c;
    logic [AW-1:0]   audio_c;
    logic [26:0]     body_c;
    logic [1:0]      preamble_c;

    assign strobe_l_c  = bus.in_valid & ~bus.in_chan;
    assign strobe_r_c  = bus.in_valid & bus.in_chan;
    assign pair_done_c = strobe_r_c & half;
    assign timeout_c   = ~bus.in_valid & (wd == WD_W'(TIMEOUT_CYC - 1));

    // Lock FSM next state
    always_comb begin
        state_next    = state;
        pair_cnt_next = pair_cnt;
        locked_next   = locked_q;
        if (timeout_c) begin
            state_next    = UNLOCKED;
            pair_cnt_next = '0;
            locked_next   = 1'b0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (strobe_l_c) begin
                        state_next    = SYNC;
                        pair_cnt_next = '0;
                    end
                end
                SYNC: begin
                    if ((strobe_l_c & half) | (strobe_r_c & ~half)) begin
                        pair_cnt_next = '0;
                    end else if (pair_done_c) begin
                        pair_cnt_next = pair_cnt + PC_W'(1);
                        if (pair_cnt == PC_W'(LOCK_PAIRS - 1)) begin
                            state_next  = LOCKED;
                            locked_next = 1'b1;
                        end
                    end
                end
                LOCKED:  state_next = LOCKED;
                default: state_next = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            pair_cnt <= '0;
            locked_q <= 1'b0;
            wd       <= '0;
        end else begin
            state    <= state_next;
            pair_cnt <= pair_cnt_next;
            locked_q <= locked_next;
            if (bus.in_valid) begin
                wd <= '0;
            end else if (wd != WD_W'(TIMEOUT_CYC)) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    // Pair buffer: completed pair kept apart from the half being assembled
    always_ff @(posedge clk) begin
        if (rst) begin
            half   <= 1'b0;
            full   <= 1'b0;
            pend_l <= '0;
            pair_l <= '0;
            pair_r <= '0;
        end else if (timeout_c) begin
            half <= 1'b0;
            full <= 1'b0;
        end else begin
            if (fetch_c & take_c) full <= 1'b0;
            if (strobe_l_c) begin
                pend_l <= bus.in_data;
                half   <= 1'b1;
            end
            if (pair_done_c) begin
                pair_l <= pend_l;
                pair_r <= bus.in_data;
                full   <= 1'b1;
                half   <= 1'b0;
            end
        end
    end

    assign present_c    = ~sf_valid_q | bus.sf_ready;
    assign next_right_c = sf_valid_q & ~is_right;
    assign fetch_c      = present_c & ~next_right_c;
    assign wrap_c       = sf_valid_q & is_right & (frame_q == LAST_FRAME);
    assign take_c       = locked_q & full;
    assign cs_eff_c     = wrap_c ? bus.cs_bits : cs_latch;

    // Next subframe contents
    always_comb begin
        frame_next_c = frame_q;
        if (!sf_valid_q || wrap_c) begin
            frame_next_c = '0;
        end else if (is_right) begin
            frame_next_c = frame_q + FW'(1);
        end
        c_bit_c    = (frame_next_c < FW'(32)) ? cs_eff_c[frame_next_c[4:0]] : 1'b0;
        audio_c    = next_right_c ? aud_r : (take_c ? pair_l : '0);
        v_c        = next_right_c ? v_hold : ~take_c;
        body_c     = {c_bit_c, 1'b0, v_c, audio_c};
        preamble_c = next_right_c ? PRE_W : ((frame_next_c == '0) ? PRE_B : PRE_M);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sf_valid_q <= 1'b0;
            is_right   <= 1'b0;
            preamble_q <= PRE_B;
            payload_q  <= '0;
            frame_q    <= '0;
            aud_r      <= '0;
            v_hold     <= 1'b1;
            underrun_q <= '0;
            cs_latch   <= CS_DEFAULT;
        end else if (present_c) begin
            sf_valid_q <= 1'b1;
            is_right   <= next_right_c;
            preamble_q <= preamble_c;
            payload_q  <= {^body_c, body_c};
            frame_q    <= frame_next_c;
            if (wrap_c) cs_latch <= bus.cs_bits;
            // Left presentation decides audio/mute for the whole frame
            if (fetch_c) begin
                aud_r  <= take_c ? pair_r : '0;
                v_hold <= ~take_c;
                if (locked_q && !full && underrun_q != 16'hFFFF) begin
                    underrun_q <= underrun_q + UW'(1);
                end
            end
        end
    end

    assign bus.sf_valid     = sf_valid_q;
    assign bus.sf_preamble  = preamble_q;
    assign bus.sf_payload   = payload_q;
    assign bus.frame_idx    = frame_q;
    assign bus.locked       = locked_q;
    assign bus.underrun_cnt = underrun_q;
endmodule
